// File: rtl/ray_issue.sv
// Ray issue stage: hands out rayIDs from a free pool and
// buffers scene-intersection misses toward shading.
package ray_pkg;
  localparam int ID_W = 9;
  typedef logic [ID_W-1:0] rayID_t;
  typedef struct packed {
    logic [2:0][31:0] orig;
    logic [2:0][31:0] dir;
  } ray_vec;
  typedef struct packed {
    ray_vec ray;
    rayID_t rayID;
    logic   is_shadow;
  } shader_to_sint_t;
  typedef struct packed {
    rayID_t rayID;
  } sint_to_shader_t;
endpackage

module ray_issue
  import ray_pkg::*;
#(
  parameter int NUM_IDS = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     raygen_valid,
  input  ray_vec                   raygen_ray,
  input  logic                     raygen_is_shadow,
  output logic                     raygen_stall,
  output logic                     shader_to_sint_valid,
  output shader_to_sint_t          shader_to_sint_data,
  input  logic                     shader_to_sint_stall,
  input  logic                     sint_to_shader_valid,
  input  sint_to_shader_t          sint_to_shader_data,
  output logic                     sint_to_shader_stall,
  output logic                     miss_valid,
  output rayID_t                   miss_rayID,
  input  logic                     miss_stall,
  input  logic                     retire_valid,
  input  rayID_t                   retire_rayID,
  output logic [$clog2(NUM_IDS):0] in_flight,
  output logic                     err_double_free,
  output logic                     err_early_retire
);
  localparam int CW = $clog2(NUM_IDS) + 1;

  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_d;

  rayID_t          pool [NUM_IDS];
  rayID_t          rd_ptr, wr_ptr, push_id;
  logic [CW-1:0]   count;
  logic            empty, full, pop, push;
  logic            out_valid;
  shader_to_sint_t out_data;

  always_comb begin
    state_d = state;
    unique case (state)
      INIT: if (wr_ptr == rayID_t'(NUM_IDS - 1)) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(NUM_IDS));

  assign raygen_stall = (state == INIT) || empty
                     || (out_valid && shader_to_sint_stall);
  assign pop = raygen_valid && !raygen_stall;

  // INIT seeds the pool with its own write index, so IDs come out 0..N-1
  assign push    = (state == INIT) || (retire_valid && !full);
  assign push_id = (state == INIT) ? wr_ptr : retire_rayID;

  always_ff @(posedge clk) begin
    if (push) pool[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= INIT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_d;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_double_free  <= 1'b0;
      err_early_retire <= 1'b0;
    end else begin
      if (retire_valid && state == RUN && full)
        err_double_free <= 1'b1;
      if (retire_valid && state == INIT)
        err_early_retire <= 1'b1;
    end
  end

  assign in_flight = (state == INIT) ? '0 : CW'(NUM_IDS) - count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= '{ray: raygen_ray,
                     rayID: pool[rd_ptr],
                     is_shadow: raygen_is_shadow};
    end else if (out_valid && !shader_to_sint_stall) begin
      out_valid <= 1'b0;
    end
  end

  assign shader_to_sint_valid = out_valid;
  assign shader_to_sint_data  = out_data;

  rayID_t     mq [2];
  logic       mwp, mrp, mwr, mrd, mfull_q;
  logic [1:0] mcnt, mcnt_d;

  assign mwr = sint_to_shader_valid && !mfull_q;
  assign mrd = miss_valid && !miss_stall;

  always_comb begin
    mcnt_d = mcnt;
    unique case ({mwr, mrd})
      2'b10:   mcnt_d = mcnt + 2'd1;
      2'b01:   mcnt_d = mcnt - 2'd1;
      default: mcnt_d = mcnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mwr) mq[mwp] <= sint_to_shader_data.rayID;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mwp     <= 1'b0;
      mrp     <= 1'b0;
      mcnt    <= '0;
      mfull_q <= 1'b0;
    end else begin
      if (mwr) mwp <= ~mwp;
      if (mrd) mrp <= ~mrp;
      mcnt    <= mcnt_d;
      mfull_q <= (mcnt_d == 2'd2);
    end
  end

  assign sint_to_shader_stall = mfull_q;
  assign miss_valid           = (mcnt != '0);
  assign miss_rayID           = mq[mrp];
endmodule

// File: tb/tb_ray_issue.sv
// Directed bench for ray_issue: pool init, issue, hold,
// miss FIFO ordering, reset recovery and error flags.
module tb_ray_issue;
  import ray_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            raygen_valid;
  ray_vec          raygen_ray;
  logic            raygen_is_shadow;
  logic            raygen_stall;
  logic            shader_to_sint_valid;
  shader_to_sint_t shader_to_sint_data;
  logic            shader_to_sint_stall;
  logic            sint_to_shader_valid;
  sint_to_shader_t sint_to_shader_data;
  logic            sint_to_shader_stall;
  logic            miss_valid;
  rayID_t          miss_rayID;
  logic            miss_stall;
  logic            retire_valid;
  rayID_t          retire_rayID;
  logic [9:0]      in_flight;
  logic            err_double_free;
  logic            err_early_retire;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  always #5 clk = ~clk;

  ray_issue #(.NUM_IDS(512)) dut (
    .clk(clk), .rst(rst),
    .raygen_valid(raygen_valid),
    .raygen_ray(raygen_ray),
    .raygen_is_shadow(raygen_is_shadow),
    .raygen_stall(raygen_stall),
    .shader_to_sint_valid(shader_to_sint_valid),
    .shader_to_sint_data(shader_to_sint_data),
    .shader_to_sint_stall(shader_to_sint_stall),
    .sint_to_shader_valid(sint_to_shader_valid),
    .sint_to_shader_data(sint_to_shader_data),
    .sint_to_shader_stall(sint_to_shader_stall),
    .miss_valid(miss_valid),
    .miss_rayID(miss_rayID),
    .miss_stall(miss_stall),
    .retire_valid(retire_valid),
    .retire_rayID(retire_rayID),
    .in_flight(in_flight),
    .err_double_free(err_double_free),
    .err_early_retire(err_early_retire)
  );

  always @(posedge clk)
    if (rst && shader_to_sint_valid && !shader_to_sint_stall)
      xfers++;

  function automatic ray_vec mk(int n);
    ray_vec r;
    for (int k = 0; k < 3; k++) begin
      r.orig[k] = 32'(n * 16 + k);
      r.dir[k]  = 32'(n * 16 + k + 8);
    end
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    step;
    step;
    rst = 1'b1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (raygen_stall && n < 2000) begin
      step;
      n++;
    end
  endtask

  task automatic test_reset;
    raygen_valid = 0; raygen_ray = '0; raygen_is_shadow = 0;
    shader_to_sint_stall = 0; sint_to_shader_valid = 0;
    sint_to_shader_data = '0; miss_stall = 0;
    retire_valid = 0; retire_rayID = '0;
    rst = 1'b0;
    step;
    step;
    checks++;
    if (raygen_stall !== 1'b1 || shader_to_sint_valid !== 1'b0
        || miss_valid !== 1'b0 || sint_to_shader_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: stall=%b v=%b mv=%b ss=%b want 1 0 0 0",
               raygen_stall, shader_to_sint_valid, miss_valid,
               sint_to_shader_stall);
    end
    checks++;
    if (in_flight !== 10'd0 || err_double_free !== 1'b0
        || err_early_retire !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt: in_flight=%0d edf=%b eer=%b want 0 0 0",
               in_flight, err_double_free, err_early_retire);
    end
    rst = 1'b1;
  endtask

  task automatic test_init_issue;
    int n;
    int bad;
    shader_to_sint_t e;
    raygen_valid = 1;
    raygen_ray = mk(0);
    do_reset;
    wait_run(n);
    checks++;
    if (n !== 512) begin
      failures++;
      $display("FAIL init_stall_cycles: got %0d want 512", n);
    end
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      raygen_ray = mk(i);
      raygen_is_shadow = i[0];
      if (raygen_stall !== 1'b0) bad++;
      step;
      e = '{ray: mk(i), rayID: rayID_t'(i), is_shadow: i[0]};
      if (i == 0) begin
        checks++;
        if (shader_to_sint_valid !== 1'b1 || shader_to_sint_data !== e) begin
          failures++;
          $display("FAIL first_issue: v=%b id=%0d want v=1 id=0",
                   shader_to_sint_valid, shader_to_sint_data.rayID);
        end
      end
      if (shader_to_sint_valid !== 1'b1 || shader_to_sint_data !== e) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL issue_seq: %0d bad cycles want 0", bad);
    end
    checks++;
    if (raygen_stall !== 1'b1 || in_flight !== 10'd512) begin
      failures++;
      $display("FAIL exhausted: stall=%b in_flight=%0d want 1 512",
               raygen_stall, in_flight);
    end
    step;
    checks++;
    if (shader_to_sint_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_valid: got %b want 0", shader_to_sint_valid);
    end
  endtask

  task automatic test_retire_reissue;
    retire_valid = 1;
    retire_rayID = 9'd7;
    raygen_ray = mk(77);
    raygen_is_shadow = 0;
    checks++;
    if (raygen_stall !== 1'b1) begin
      failures++;
      $display("FAIL no_bypass_stall: got %b want 1", raygen_stall);
    end
    step;
    retire_valid = 0;
    checks++;
    if (shader_to_sint_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass_issue: valid=%b want 0",
               shader_to_sint_valid);
    end
    step;
    checks++;
    if (shader_to_sint_valid !== 1'b1
        || shader_to_sint_data.rayID !== 9'd7) begin
      failures++;
      $display("FAIL reissue7: v=%b id=%0d want 1 7",
               shader_to_sint_valid, shader_to_sint_data.rayID);
    end
    raygen_valid = 0;
    step;
    checks++;
    if (in_flight !== 10'd512) begin
      failures++;
      $display("FAIL reissue_inflight: got %0d want 512", in_flight);
    end
  endtask

  task automatic test_stall_hold;
    int bad;
    int x0;
    shader_to_sint_t e;
    for (int i = 20; i < 30; i++) begin
      retire_valid = 1;
      retire_rayID = rayID_t'(i);
      step;
    end
    retire_valid = 0;
    checks++;
    if (in_flight !== 10'd502) begin
      failures++;
      $display("FAIL retire10_inflight: got %0d want 502", in_flight);
    end
    shader_to_sint_stall = 1;
    raygen_valid = 1;
    raygen_ray = mk(100);
    raygen_is_shadow = 1;
    step;
    raygen_ray = mk(200);
    raygen_is_shadow = 0;
    x0 = xfers;
    e = '{ray: mk(100), rayID: 9'd20, is_shadow: 1'b1};
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (shader_to_sint_valid !== 1'b1 || shader_to_sint_data !== e
          || raygen_stall !== 1'b1) bad++;
      if (k < 4) step;
    end
    checks++;
    if (bad !== 0 || xfers !== x0) begin
      failures++;
      $display("FAIL hold: bad=%0d xfers=%0d want 0 %0d", bad, xfers, x0);
    end
    shader_to_sint_stall = 0;
    raygen_valid = 0;
    step;
    checks++;
    if (shader_to_sint_valid !== 1'b0 || xfers !== x0 + 1) begin
      failures++;
      $display("FAIL one_xfer: v=%b xfers=%0d want 0 %0d",
               shader_to_sint_valid, xfers - x0, 1);
    end
  endtask

  task automatic test_miss_fifo;
    rayID_t got[$];
    logic take;
    miss_stall = 1;
    sint_to_shader_valid = 1;
    sint_to_shader_data.rayID = 9'd3;
    step;
    sint_to_shader_data.rayID = 9'd4;
    step;
    sint_to_shader_data.rayID = 9'd5;
    checks++;
    if (sint_to_shader_stall !== 1'b1 || miss_valid !== 1'b1
        || miss_rayID !== 9'd3) begin
      failures++;
      $display("FAIL miss_full: ss=%b mv=%b id=%0d want 1 1 3",
               sint_to_shader_stall, miss_valid, miss_rayID);
    end
    step;
    step;
    checks++;
    if (sint_to_shader_stall !== 1'b1 || miss_rayID !== 9'd3) begin
      failures++;
      $display("FAIL miss_hold: ss=%b id=%0d want 1 3",
               sint_to_shader_stall, miss_rayID);
    end
    miss_stall = 0;
    for (int c = 0; c < 10; c++) begin
      if (miss_valid) got.push_back(miss_rayID);
      take = sint_to_shader_valid && !sint_to_shader_stall;
      step;
      if (take) sint_to_shader_valid = 0;
    end
    checks++;
    if (got.size() !== 3 || got[0] !== 9'd3 || got[1] !== 9'd4
        || got[2] !== 9'd5) begin
      failures++;
      $display("FAIL miss_order: n=%0d first=%0d want 3 ids 3,4,5",
               got.size(), got.size() > 0 ? got[0] : 9'd0);
    end
    checks++;
    if (miss_valid !== 1'b0 || sint_to_shader_stall !== 1'b0) begin
      failures++;
      $display("FAIL miss_empty: mv=%b ss=%b want 0 0",
               miss_valid, sint_to_shader_stall);
    end
  endtask

  task automatic test_midflight_reset;
    int n;
    raygen_valid = 0;
    do_reset;
    wait_run(n);
    raygen_valid = 1;
    for (int i = 0; i < 10; i++) step;
    raygen_valid = 0;
    step;
    checks++;
    if (in_flight !== 10'd10) begin
      failures++;
      $display("FAIL ten_inflight: got %0d want 10", in_flight);
    end
    miss_stall = 1;
    sint_to_shader_valid = 1;
    sint_to_shader_data.rayID = 9'd11;
    step;
    sint_to_shader_valid = 0;
    rst = 1'b0;
    step;
    checks++;
    if (in_flight !== 10'd0 || raygen_stall !== 1'b1
        || shader_to_sint_valid !== 1'b0 || miss_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset: inf=%0d st=%b v=%b mv=%b want 0 1 0 0",
               in_flight, raygen_stall, shader_to_sint_valid, miss_valid);
    end
    rst = 1'b1;
    miss_stall = 0;
    raygen_valid = 1;
    wait_run(n);
    checks++;
    if (n !== 512) begin
      failures++;
      $display("FAIL reinit_cycles: got %0d want 512", n);
    end
    step;
    raygen_valid = 0;
    checks++;
    if (shader_to_sint_valid !== 1'b1
        || shader_to_sint_data.rayID !== 9'd0) begin
      failures++;
      $display("FAIL reinit_id0: v=%b id=%0d want 1 0",
               shader_to_sint_valid, shader_to_sint_data.rayID);
    end
    step;
  endtask

  task automatic test_errors;
    int n;
    raygen_valid = 0;
    do_reset;
    retire_valid = 1;
    retire_rayID = 9'd3;
    step;
    retire_valid = 0;
    checks++;
    if (err_early_retire !== 1'b1 || err_double_free !== 1'b0) begin
      failures++;
      $display("FAIL early_retire: eer=%b edf=%b want 1 0",
               err_early_retire, err_double_free);
    end
    wait_run(n);
    checks++;
    if (n !== 511 || in_flight !== 10'd0) begin
      failures++;
      $display("FAIL init_after_early: n=%0d inf=%0d want 511 0",
               n, in_flight);
    end
    retire_valid = 1;
    retire_rayID = 9'd9;
    step;
    retire_valid = 0;
    checks++;
    if (err_double_free !== 1'b1 || in_flight !== 10'd0) begin
      failures++;
      $display("FAIL double_free: edf=%b inf=%0d want 1 0",
               err_double_free, in_flight);
    end
    step;
    step;
    checks++;
    if (err_double_free !== 1'b1 || err_early_retire !== 1'b1) begin
      failures++;
      $display("FAIL sticky: edf=%b eer=%b want 1 1",
               err_double_free, err_early_retire);
    end
    raygen_valid = 1;
    step;
    raygen_valid = 0;
    checks++;
    if (shader_to_sint_valid !== 1'b1
        || shader_to_sint_data.rayID !== 9'd0) begin
      failures++;
      $display("FAIL pool_intact: v=%b id=%0d want 1 0",
               shader_to_sint_valid, shader_to_sint_data.rayID);
    end
    step;
  endtask

  initial begin
    test_reset;
    test_init_issue;
    test_retire_reissue;
    test_stall_hold;
    test_miss_fifo;
    test_midflight_reset;
    test_errors;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ray_issue.md
RAY_ISSUE -- requirements
Module: ray_issue

Interface
REQ-001 Parameter NUM_IDS, 512, number of rayIDs managed; equals 2^$bits(rayID_t).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 raygen_valid  in  1  new ray offered by ray generator / shader.
REQ-005 raygen_ray  in  $bits(ray_vec)  ray origin and direction.
REQ-006 raygen_is_shadow  in  1  ray is a shadow ray.
REQ-007 raygen_stall  out  1  ray not accepted this cycle.
REQ-008 shader_to_sint_valid  out  1  issued ray valid toward scene_int.
REQ-009 shader_to_sint_data  out  shader_to_sint_t  {ray_vec, rayID, is_shadow}.
REQ-010 shader_to_sint_stall  in  1  scene_int cannot accept.
REQ-011 sint_to_shader_valid  in  1  miss notification from scene_int.
REQ-012 sint_to_shader_data  in  sint_to_shader_t  rayID of missed ray.
REQ-013 sint_to_shader_stall  out  1  miss notification not accepted.
REQ-014 miss_valid / miss_rayID / miss_stall  out/out/in  1/$bits(rayID_t)/1  miss stream to shading.
REQ-015 retire_valid / retire_rayID  in/in  1/$bits(rayID_t)  rayID returned to free pool.
REQ-016 in_flight  out  $clog2(NUM_IDS)+1  rayIDs currently allocated.
REQ-017 err_double_free / err_early_retire  out  1/1  sticky error flags.

Function
REQ-018 Free pool SHALL be a FIFO of depth NUM_IDS holding rayIDs; pop on issue, push on retire.
REQ-019 FSM states SHALL be INIT and RUN; INIT entered on reset.
REQ-020 INIT SHALL push one rayID per cycle, values 0,1,...,NUM_IDS-1 in order, then go to RUN the cycle after pushing NUM_IDS-1 (NUM_IDS cycles in INIT).
REQ-021 raygen_stall SHALL equal (state==INIT) || pool empty || (shader_to_sint_valid && shader_to_sint_stall).
REQ-022 Accept = raygen_valid && !raygen_stall; on accept the output register SHALL load {raygen_ray, popped rayID, raygen_is_shadow} and set shader_to_sint_valid next cycle (latency 1).
REQ-023 While shader_to_sint_valid && shader_to_sint_stall, shader_to_sint_data and valid SHALL hold stable.
REQ-024 shader_to_sint_valid SHALL clear when the held ray transfers (valid && !stall) with no accept that cycle; transfer and accept in the same cycle SHALL give back-to-back issue.
REQ-025 No bypass: a retire to an empty pool SHALL not be issued in the same cycle; issue becomes possible the next cycle.
REQ-026 Retire in RUN SHALL push retire_rayID unless pool count == NUM_IDS, in which case the push is dropped and err_double_free sets.
REQ-027 Retire in INIT SHALL be dropped and set err_early_retire.
REQ-028 Simultaneous pop and push SHALL leave pool count unchanged and both operations SHALL complete.
REQ-029 in_flight SHALL equal NUM_IDS minus pool count in RUN, and 0 in INIT.
REQ-030 Miss path SHALL be a 2-entry FIFO: write on sint_to_shader_valid && !sint_to_shader_stall; miss_valid = not empty; read on miss_valid && !miss_stall.
REQ-031 sint_to_shader_stall SHALL be registered, equal to (miss FIFO count == 2); a simultaneous read and write at count 1 SHALL keep count 1.
REQ-032 Miss FIFO SHALL preserve order; rayIDs are not released by the miss path (shading retires them).

Reset
REQ-033 On rst low at a clock edge: state=INIT, pool empty and write index 0, output and miss registers invalid, in_flight=0, error flags 0, raygen_stall=1, sint_to_shader_stall=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight rays and queued misses and restart INIT.

Verification
REQ-035 Reset, raygen_valid held 1, no stall -> raygen_stall 1 for 512 cycles, then rayIDs 0,1,2,... issued on consecutive cycles.
REQ-036 Issue 512 rays, no retire -> raygen_stall 1 with in_flight=512; retire rayID 7 -> next-cycle issue carries rayID 7.
REQ-037 shader_to_sint_stall held 5 cycles with valid ray -> data unchanged for 5 cycles, raygen_stall 1, exactly one transfer.
REQ-038 Misses 3,4,5 back-to-back, miss_stall 1 -> sint_to_shader_stall 1 after two entries; release -> miss_rayID 3,4,5 in order.
REQ-039 Retire rayID 9 when pool full -> err_double_free 1, pool count stays 512; retire during INIT -> err_early_retire 1.
REQ-040 Reset asserted with 10 rays in flight -> in_flight 0 next cycle, INIT restarts from rayID 0.
